pwm_gen: RTL

- Downstream PWM generator that consumes pwm_ratio/pwm_update/pwm_enable from pwm_ctrl.
- Returns a one-cycle pwm_done pulse once the requested ratio is fully in effect.
- Produces the motor PWM output with a 255-tick period.
- Slew-limits duty changes once per period to protect the motor driver.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_gen_if.sv | 30 +++
 rtl/pwm_tick_gen.sv | 32 +++
 rtl/pwm_gen.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator: ratio width, period
// length and ramp FSM state encoding.
package pwm_pkg;

  localparam int RATIO_W = 8;

  typedef logic [RATIO_W-1:0] ratio_t;

  localparam ratio_t PWM_CNT_MAX = 8'd254;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage : pwm_pkg

// File: rtl/pwm_gen_if.sv
// Control/status bundle between pwm_ctrl (master) and pwm_gen (slave).
interface pwm_gen_if;
  import pwm_pkg::*;

  logic   pwm_enable;
  logic   pwm_update;
  ratio_t pwm_ratio;
  logic   pwm_done;
  logic   pwm_signal;
  ratio_t applied_ratio;

  modport master (
    output pwm_enable,
    output pwm_update,
    output pwm_ratio,
    input  pwm_done,
    input  pwm_signal,
    input  applied_ratio
  );

  modport slave (
    input  pwm_enable,
    input  pwm_update,
    input  pwm_ratio,
    output pwm_done,
    output pwm_signal,
    output applied_ratio
  );

endinterface : pwm_gen_if

// File: rtl/pwm_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE clocks, held at zero while clear is high.
module pwm_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] pre_q, pre_d;

  always_comb begin
    tick  = !clear && (pre_q == LAST);
    pre_d = pre_q + 1'b1;
    if (clear || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule : pwm_tick_gen

// File: rtl/pwm_gen.sv
// Motor PWM generator: 255-tick period, duty slew-limited to RAMP_STEP per
// period, with a one-cycle done pulse once the requested ratio is in effect.
//
// state | meaning
// IDLE  | applied duty settled, waiting for a request
// RAMP  | stepping applied duty toward target at each period end
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int RAMP_STEP = 8
) (
  input logic        clock,
  input logic        reset_n,
  pwm_gen_if.slave   bus
);

  localparam logic [RATIO_W:0] STEP9 = (RATIO_W + 1)'(RAMP_STEP);

  logic   tick;
  logic   period_end;
  logic   enable;

  state_e state_q, state_d;
  ratio_t cnt_q, cnt_d;
  ratio_t target_q, target_d;
  ratio_t applied_q, applied_d;
  logic   done_q, done_d;
  logic   sig_q, sig_d;

  logic             up;
  logic [RATIO_W:0] mag;

  assign enable = bus.pwm_enable;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!enable),
    .tick    (tick)
  );

  assign period_end = tick && (cnt_q == PWM_CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == PWM_CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Unsigned 9-bit magnitude avoids any wrap when stepping toward target.
  always_comb begin
    up  = target_q >= applied_q;
    mag = up ? ({1'b0, target_q} - {1'b0, applied_q})
             : ({1'b0, applied_q} - {1'b0, target_q});
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    applied_d = applied_q;
    done_d    = 1'b0;
    sig_d     = enable && (cnt_q < applied_q);

    if (!enable) begin
      state_d   = IDLE;
      applied_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.pwm_update) begin
            target_d = bus.pwm_ratio;
            state_d  = RAMP;
          end
        end
        RAMP: begin
          if (period_end) begin
            if (mag <= STEP9) begin
              applied_d = target_q;
              if (!bus.pwm_update) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else if (up) begin
              applied_d = applied_q + RATIO_W'(RAMP_STEP);
            end else begin
              applied_d = applied_q - RATIO_W'(RAMP_STEP);
            end
          end
          // A retarget supersedes the old request; its step above still used the old target.
          if (bus.pwm_update) begin
            target_d = bus.pwm_ratio;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= '0;
      applied_q <= '0;
      done_q    <= 1'b0;
      sig_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      done_q    <= done_d;
      sig_q     <= sig_d;
    end
  end

  assign bus.pwm_done      = done_q;
  assign bus.pwm_signal    = sig_q;
  assign bus.applied_ratio = applied_q;

endmodule : pwm_gen
